// File: rtl/vga_timing_detect.sv
// Receive-side VGA timing detector: measures line/frame periods, locks after consistent
// frames and regenerates active-area coordinates. Define VGA_POLARITY_DETECT_EN for sync polarity auto-detect.
module vga_timing_detect #(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int H_OFFSET    = 297,
  parameter int V_OFFSET    = 35,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic        o_locked,
  output logic [11:0] o_h_total,
  output logic [10:0] o_v_total,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_active,
  output logic        o_frame_start,
  output logic        o_err
`ifdef VGA_POLARITY_DETECT_EN
  ,
  output logic        o_hs_pol,
  output logic        o_vs_pol
`endif
);

  localparam logic [11:0] H_LO      = 12'(H_OFFSET);
  localparam logic [11:0] H_HI      = 12'(H_OFFSET + H_ACTIVE);
  localparam logic [10:0] V_LO      = 11'(V_OFFSET);
  localparam logic [10:0] V_HI      = 11'(V_OFFSET + V_ACTIVE);
  localparam logic [7:0]  LOCK_N    = 8'(LOCK_FRAMES);
  localparam logic [11:0] HPOS_MAX  = 12'hFFF;
  localparam logic [10:0] VLINE_MAX = 11'h7FF;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state, state_nxt;

  logic        hs_hist, vs_hist, hs_pol, vs_pol, pol_change;
  logic        hs_start, vs_start;
  logic [11:0] hpos, hpos_nxt, line_len, last_len, h_cand, prev_h;
  logic [10:0] vline, vline_nxt, line_cnt, v_cand, prev_v;
  logic [10:0] x_nxt, y_nxt;
  logic        vs_seen, lines_bad, lines_bad_cls, prev_valid, match_ok;
  logic [7:0]  match_cnt, cnt_nxt;
  logic        lock_hit, loss, err_now, locked_nxt, latch_tot, active_nxt;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == HPOS_MAX) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == VLINE_MAX) ? v : v + 11'd1;
  endfunction

  // History regs hold raw pin levels; polarity is applied on both sides of the edge test.
  assign hs_start = i_pix_stb & (hs_hist ^ hs_pol) & ~(i_hs ^ hs_pol);
  assign vs_start = i_pix_stb & (vs_hist ^ vs_pol) & ~(i_vs ^ vs_pol);

  always_comb begin
    line_len      = sat_inc12(hpos);
    // The first line closed after a vsync start straddles the frame edge, so it only seeds the compare.
    lines_bad_cls = lines_bad | (hs_start & ~vs_seen & (line_len != last_len));
    h_cand        = hs_start ? line_len : last_len;
    v_cand        = hs_start ? sat_inc11(line_cnt) : line_cnt;
    hpos_nxt      = hpos;
    vline_nxt     = vline;
    if (i_pix_stb) begin
      hpos_nxt = hs_start ? 12'd0 : sat_inc12(hpos);
      if (hs_start) vline_nxt = vs_seen ? 11'd0 : sat_inc11(vline);
    end
    match_ok = ~lines_bad_cls & ~pol_change &
               (~prev_valid | ((h_cand == prev_h) & (v_cand == prev_v)));
    cnt_nxt  = match_cnt;
    if (state != MEASURE)  cnt_nxt = 8'd0;
    else if (vs_start)     cnt_nxt = match_ok ? match_cnt + 8'd1 : 8'd0;
    lock_hit = (state == MEASURE) & vs_start & (cnt_nxt >= LOCK_N);
    loss     = (hs_start & (line_len != o_h_total)) |
               (vs_start & ((v_cand != o_v_total) | pol_change)) |
               (i_pix_stb & ~hs_start & (hpos == HPOS_MAX - 12'd1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= SEARCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (vs_start) state_nxt = MEASURE;
      MEASURE: if (lock_hit) state_nxt = LOCKED;
      LOCKED:  if (loss)     state_nxt = SEARCH;
      default:               state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    err_now    = (state == LOCKED) & loss;
    latch_tot  = lock_hit;
    locked_nxt = (state_nxt == LOCKED);
    active_nxt = locked_nxt & (hpos_nxt >= H_LO) & (hpos_nxt < H_HI) &
                 (vline_nxt >= V_LO) & (vline_nxt < V_HI);
    x_nxt      = active_nxt ? 11'(hpos_nxt - H_LO) : 11'd0;
    y_nxt      = active_nxt ? (vline_nxt - V_LO) : 11'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_hist       <= 1'b1;
      vs_hist       <= 1'b1;
      hpos          <= '0;
      vline         <= '0;
      last_len      <= '0;
      line_cnt      <= '0;
      lines_bad     <= 1'b0;
      vs_seen       <= 1'b0;
      prev_h        <= '0;
      prev_v        <= '0;
      prev_valid    <= 1'b0;
      match_cnt     <= '0;
      o_h_total     <= '0;
      o_v_total     <= '0;
      o_locked      <= 1'b0;
      o_active      <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
    end else if (i_pix_stb) begin
      hs_hist   <= i_hs;
      vs_hist   <= i_vs;
      hpos      <= hpos_nxt;
      vline     <= vline_nxt;
      match_cnt <= cnt_nxt;
      if (hs_start) last_len <= line_len;
      // Line closed on this strobe belongs to the frame that vsync closes.
      if (vs_start) begin
        line_cnt   <= '0;
        lines_bad  <= 1'b0;
        vs_seen    <= 1'b1;
        prev_h     <= h_cand;
        prev_v     <= v_cand;
        prev_valid <= (state != SEARCH);
      end else begin
        lines_bad <= lines_bad_cls;
        if (hs_start) begin
          line_cnt <= sat_inc11(line_cnt);
          vs_seen  <= 1'b0;
        end
      end
      if (latch_tot) begin
        o_h_total <= h_cand;
        o_v_total <= v_cand;
      end
      o_locked      <= locked_nxt;
      o_active      <= active_nxt;
      o_x           <= x_nxt;
      o_y           <= y_nxt;
      o_frame_start <= vs_start;
      o_err         <= err_now;
    end else begin
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
    end
  end

`ifdef VGA_POLARITY_DETECT_EN
  logic [11:0] hs_low_cnt, hs_low_last, hs_low_cls;
  logic [10:0] vs_low_lines, vs_low_cls;
  logic        hs_pol_new, vs_pol_new;

  // Raw low time per line and raw low lines per frame decide which level is the sync pulse.
  always_comb begin
    hs_low_cls = hs_start ? hs_low_cnt : hs_low_last;
    vs_low_cls = (hs_start & ~i_vs) ? sat_inc11(vs_low_lines) : vs_low_lines;
    hs_pol_new = {hs_low_cls, 1'b0} > {1'b0, h_cand};
    vs_pol_new = {vs_low_cls, 1'b0} > {1'b0, v_cand};
    pol_change = vs_start & ((hs_pol_new != hs_pol) | (vs_pol_new != vs_pol));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_low_cnt   <= '0;
      hs_low_last  <= '0;
      vs_low_lines <= '0;
      hs_pol       <= 1'b0;
      vs_pol       <= 1'b0;
    end else if (i_pix_stb) begin
      if (hs_start) begin
        hs_low_last <= hs_low_cnt;
        hs_low_cnt  <= {11'd0, ~i_hs};
      end else if (!i_hs) begin
        hs_low_cnt <= sat_inc12(hs_low_cnt);
      end
      vs_low_lines <= vs_start ? 11'd0 : vs_low_cls;
      if (vs_start) begin
        hs_pol <= hs_pol_new;
        vs_pol <= vs_pol_new;
      end
    end
  end

  assign o_hs_pol = hs_pol;
  assign o_vs_pol = vs_pol;
`else
  assign hs_pol     = 1'b0;
  assign vs_pol     = 1'b0;
  assign pol_change = 1'b0;
`endif

endmodule
